// File: rtl/approx_mul_pkg.sv
// Shared constants and the golden arithmetic reference for the approximate multiplier.
package approx_mul_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    localparam int unsigned DEF_W      = 8;
    localparam int unsigned DEF_DROP   = 2;
    localparam int unsigned DEF_STAGES = 2;
    localparam int unsigned DEF_TAG_W  = 4;
    localparam int unsigned DEF_CNT_W  = 16;

    // Untruncated signed result; callers keep the low 2*W bits.
    function automatic longint approx_ref(input longint a, input longint b,
                                          input logic mode, input int unsigned drop);
        if (mode == MODE_APPROX)
            return ((a >>> drop) * (b >>> drop)) <<< (2 * drop);
        return a * b;
    endfunction

endpackage

// File: rtl/approx_mul_core.sv
// Combinational signed partial-product array; approximate mode drops the low
// DROP rows (multiplier bits) and low DROP columns (multiplicand bits).
module approx_mul_core
    import approx_mul_pkg::*;
#(
    parameter int unsigned W    = DEF_W,
    parameter int unsigned DROP = DEF_DROP
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           mode,
    output logic [2*W-1:0] p_c
);

    localparam int unsigned PW = 2 * W;
    localparam logic [W-1:0] LOW_MASK = W'((2 ** DROP) - 1);

    logic          approx;
    logic [W-1:0]  a_m;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] acc;

    // Row j is the sign-extended multiplicand weighted by b[j]; the sign row subtracts.
    always_comb begin
        approx = (mode == MODE_APPROX);
        a_m    = approx ? (a & ~LOW_MASK) : a;
        a_ext  = PW'($signed(a_m));
        acc    = '0;
        for (int unsigned j = 0; j < W; j++) begin
            if (b[j] && !(approx && (j < DROP))) begin
                if (j == W - 1)
                    acc = acc - (a_ext << j);
                else
                    acc = acc + (a_ext << j);
            end
        end
        p_c = acc;
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined exact/approximate signed multiplier with valid/ready handshake.
// Optional per-mode statistics counters built when APPROX_MUL_STATS_EN is defined.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int unsigned W      = DEF_W,
    parameter int unsigned DROP   = DEF_DROP,
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic             out_mode,
    output logic [TAG_W-1:0] out_tag,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_exact_cnt,
    output logic [CNT_W-1:0] stat_approx_cnt
);

    localparam int unsigned PW = 2 * W;

    logic              adv_c;
    logic [PW-1:0]     core_p_c;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] mode_q, mode_d;
    logic [PW-1:0]     prod_q [STAGES];
    logic [PW-1:0]     prod_d [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];

    approx_mul_core #(.W(W), .DROP(DROP)) u_core (
        .a    (in_a),
        .b    (in_b),
        .mode (in_mode),
        .p_c  (core_p_c)
    );

    // The whole pipe moves only when the output slot is free or being drained.
    assign adv_c    = !(vld_q[STAGES-1] && !out_ready);
    assign in_ready = adv_c;

    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        prod_d = prod_q;
        tag_d  = tag_q;
        if (adv_c) begin
            vld_d[0]  = in_valid;
            mode_d[0] = in_mode;
            prod_d[0] = core_p_c;
            tag_d[0]  = in_tag;
            for (int unsigned s = 1; s < STAGES; s++) begin
                vld_d[s]  = vld_q[s-1];
                mode_d[s] = mode_q[s-1];
                prod_d[s] = prod_q[s-1];
                tag_d[s]  = tag_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            mode_q <= {STAGES{MODE_EXACT}};
            for (int unsigned s = 0; s < STAGES; s++) begin
                prod_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            prod_q <= prod_d;
            tag_q  <= tag_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];
    assign out_p     = prod_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

`ifdef APPROX_MUL_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] exact_cnt_q, exact_cnt_d;
    logic [CNT_W-1:0] approx_cnt_q, approx_cnt_d;

    // Clear wins over a same-cycle increment; counts saturate.
    always_comb begin
        exact_cnt_d  = exact_cnt_q;
        approx_cnt_d = approx_cnt_q;
        if (stat_clr) begin
            exact_cnt_d  = '0;
            approx_cnt_d = '0;
        end else if (in_valid && adv_c) begin
            if (in_mode == MODE_APPROX) begin
                if (approx_cnt_q != CNT_MAX)
                    approx_cnt_d = approx_cnt_q + CNT_W'(1);
            end else begin
                if (exact_cnt_q != CNT_MAX)
                    exact_cnt_d = exact_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exact_cnt_q  <= '0;
            approx_cnt_q <= '0;
        end else begin
            exact_cnt_q  <= exact_cnt_d;
            approx_cnt_q <= approx_cnt_d;
        end
    end

    assign stat_exact_cnt  = exact_cnt_q;
    assign stat_approx_cnt = approx_cnt_q;
`else
    logic stat_clr_unused;
    assign stat_clr_unused = stat_clr;
    assign stat_exact_cnt  = '0;
    assign stat_approx_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Randomized self-checking bench for approx_mul_pipe with a queue scoreboard.
// Statistics checks follow APPROX_MUL_STATS_EN.
module tb_approx_mul_pipe;
    import approx_mul_pkg::*;

    localparam int unsigned W      = 8;
    localparam int unsigned DROP   = 2;
    localparam int unsigned STAGES = 2;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PW     = 2 * W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic             in_mode = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [PW-1:0]    out_p;
    logic             out_mode;
    logic [TAG_W-1:0] out_tag;
    logic             stat_clr = 1'b0;
    logic [CNT_W-1:0] stat_exact_cnt;
    logic [CNT_W-1:0] stat_approx_cnt;

    logic             sat_in_ready;
    logic             sat_out_valid;
    logic [PW-1:0]    sat_out_p;
    logic             sat_out_mode;
    logic [TAG_W-1:0] sat_out_tag;
    logic [3:0]       sat_exact_cnt;
    logic [3:0]       sat_approx_cnt;

    approx_mul_pipe #(.W(W), .DROP(DROP), .STAGES(STAGES), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_mode(out_mode), .out_tag(out_tag),
        .stat_clr(stat_clr),
        .stat_exact_cnt(stat_exact_cnt), .stat_approx_cnt(stat_approx_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    approx_mul_pipe #(.W(W), .DROP(DROP), .STAGES(STAGES), .TAG_W(TAG_W), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_p(sat_out_p), .out_mode(sat_out_mode), .out_tag(sat_out_tag),
        .stat_clr(stat_clr),
        .stat_exact_cnt(sat_exact_cnt), .stat_approx_cnt(sat_approx_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [PW-1:0]    p;
        logic             mode;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             sb_e;
    logic [TAG_W-1:0] seen_tags[$];
    int               out_cnt = 0;
    logic             prev_stall = 1'b0;
    logic [PW-1:0]    prev_p = '0;
    logic [TAG_W-1:0] prev_tag = '0;
    logic             prev_mode = 1'b0;

    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic mode);
        longint r;
        r = approx_ref(longint'($signed(a)), longint'($signed(b)), mode, DROP);
        return PW'(r);
    endfunction

    // Monitor on the falling edge: score outputs, hold-under-stall, record inputs.
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_p", 64'(out_p), 64'(prev_p));
                check("hold_tag", 64'(out_tag), 64'(prev_tag));
                check("hold_mode", 64'(out_mode), 64'(prev_mode));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 64'(out_tag), 64'hDEAD);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_p", 64'(out_p), 64'(sb_e.p));
                    check("sb_mode", 64'(out_mode), 64'(sb_e.mode));
                    check("sb_tag", 64'(out_tag), 64'(sb_e.tag));
                end
                seen_tags.push_back(out_tag);
                out_cnt++;
            end
            if (in_valid && in_ready)
                sb_q.push_back('{model(in_a, in_b, in_mode), in_mode, in_tag});
            prev_stall = out_valid && !out_ready;
            prev_p     = out_p;
            prev_tag   = out_tag;
            prev_mode  = out_mode;
        end
    end

    task automatic rand_inputs();
        in_a    = W'($urandom);
        in_b    = W'($urandom);
        in_mode = 1'($urandom);
        in_tag  = TAG_W'($urandom);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Single transfer into an idle pipe; checks exact two-cycle latency and result.
    task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic mode, input logic [PW-1:0] exp);
        in_a = a; in_b = b; in_mode = mode; in_tag = TAG_W'($urandom);
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({nm, "_lat1"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check({nm, "_lat2"}, 64'(out_valid), 64'(1));
        check(nm, 64'(out_p), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  nxt;
        int  lowready;
        logic took;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_p", 64'(out_p), 64'(0));
        check("rst_out_mode", 64'(out_mode), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_exact_cnt", 64'(stat_exact_cnt), 64'(0));
        check("rst_approx_cnt", 64'(stat_approx_cnt), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed arithmetic and corner cases
        directed("exact_7x7",       8'h07, 8'h07, MODE_EXACT,  16'h0031);
        directed("approx_7x7",      8'h07, 8'h07, MODE_APPROX, 16'h0010);
        directed("exact_m128sq",    8'h80, 8'h80, MODE_EXACT,  16'h4000);
        directed("approx_m128sq",   8'h80, 8'h80, MODE_APPROX, 16'h4000);
        directed("exact_127xm128",  8'h7F, 8'h80, MODE_EXACT,  16'hC080);
        directed("approx_127xm128", 8'h7F, 8'h80, MODE_APPROX, 16'hC200);
        directed("exact_m1x1",      8'hFF, 8'h01, MODE_EXACT,  16'hFFFF);
        directed("approx_m1x1",     8'hFF, 8'h01, MODE_APPROX, 16'h0000);

        // Stall: tags 0..7 back to back, downstream blocked on cycles 4..8
        seen_tags.delete();
        nxt = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 60 && seen_tags.size() < 8; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            if (!in_valid && nxt < 8) begin
                rand_inputs();
                in_tag = TAG_W'(nxt);
                in_valid = 1'b1;
            end
            #1;
            if (c >= 4 && c <= 8)
                check("stall_in_ready", 64'(in_ready), 64'(0));
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took) begin
                nxt++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stall_count", 64'(seen_tags.size()), 64'(8));
        for (int i = 0; i < 8 && i < seen_tags.size(); i++)
            check("stall_order", 64'(seen_tags[i]), 64'(i));

        // Throughput: 100 random transfers with the sink always ready
        @(posedge clk); #1;
        out_cnt = 0;
        lowready = 0;
        for (int c = 0; c < 102; c++) begin
            if (c < 100) begin
                rand_inputs();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!in_ready) lowready++;
            @(posedge clk); #1;
        end
        check("tput_count", 64'(out_cnt), 64'(100));
        check("tput_in_ready", 64'(lowready), 64'(0));

        // Reset with two transactions in flight
        out_ready = 1'b0;
        rand_inputs();
        in_valid = 1'b1;
        @(posedge clk); #1;
        rand_inputs();
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_pre_valid", 64'(out_valid), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_async_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("mid_no_stale", 64'(out_valid), 64'(0));
        end
        directed("post_rst", 8'h05, 8'hFD, MODE_EXACT, 16'hFFF1);

        // Statistics
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_inputs();
            in_mode = (i >= 5) ? MODE_APPROX : MODE_EXACT;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
`ifdef APPROX_MUL_STATS_EN
        check("stat_exact5", 64'(stat_exact_cnt), 64'(5));
        check("stat_approx3", 64'(stat_approx_cnt), 64'(3));
`else
        check("stat_off_exact", 64'(stat_exact_cnt), 64'(0));
        check("stat_off_approx", 64'(stat_approx_cnt), 64'(0));
`endif
        rand_inputs();
        in_mode = MODE_APPROX;
        in_valid = 1'b1;
        stat_clr = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        stat_clr = 1'b0;
        check("stat_clr_exact", 64'(stat_exact_cnt), 64'(0));
        check("stat_clr_approx", 64'(stat_approx_cnt), 64'(0));
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            in_mode = MODE_APPROX;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
`ifdef APPROX_MUL_STATS_EN
        check("stat_approx20", 64'(stat_approx_cnt), 64'(20));
        check("stat_sat15", 64'(sat_approx_cnt), 64'(15));
`else
        check("stat_off_approx20", 64'(stat_approx_cnt), 64'(0));
        check("stat_off_sat", 64'(sat_approx_cnt), 64'(0));
`endif
        check("stat_sat_exact", 64'(sat_exact_cnt), 64'(0));

        // Drain and confirm nothing was lost
        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_mul_pipe.md
Name: approx_mul_pipe

Overview:
- Parametrised, pipelined signed multiplier for the approximate-arithmetic datapath; next generation of the fixed 8x8 registered approximate multiplier.
- Each transaction selects exact or approximate mode. Approximate mode drops the low DROP rows and low DROP columns of the partial-product array.
- Valid/ready handshake on input and output; configurable latency; optional per-mode transaction statistics.
- Sits between the operand source and the error-analysis / accumulation stages.

Parameters:
- W, 8, operand width in bits (signed two's complement); legal 4..16.
- DROP, 2, partial-product rows/columns dropped in approximate mode; legal 0..W-2.
- STAGES, 2, pipeline register stages (latency in cycles); legal 1..4.
- TAG_W, 4, width of the sideband tag passed through unchanged.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  W  signed multiplicand.
- in_b  in  W  signed multiplier.
- in_mode  in  1  0 = exact, 1 = approximate.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_p  out  2W  signed product.
- out_mode  out  1  mode of the transaction presented on out_p.
- out_tag  out  TAG_W  tag of the transaction presented on out_p.
- stat_clr  in  1  synchronous clear of the statistics counters.
- stat_exact_cnt  out  CNT_W  accepted exact-mode transactions.
- stat_approx_cnt  out  CNT_W  accepted approximate-mode transactions.

Behaviour:
- Reset (rst=0, asynchronous): all stage valid flags clear. out_valid=0, out_p=0, out_mode=0, out_tag=0, counters=0. in_ready=1 from the first cycle after reset deassertion.
- Arithmetic:
  - Exact mode: out_p = in_a * in_b, full 2W-bit signed product.
  - Approximate mode: out_p = ((in_a >>> DROP) * (in_b >>> DROP)) << (2*DROP), truncated to 2W bits. This equals keeping only partial products a_i*b_j with i>=DROP and j>=DROP (Baugh-Wooley signed weighting).
  - In approximate mode, out_p[2*DROP-1:0] is always 0. DROP=0 makes both modes identical.
- Pipeline:
  - STAGES register stages; each stage carries valid, product, mode and tag.
  - Global advance signal adv = !(out_valid && !out_ready).
  - When adv=1, every stage shifts forward. A stage with no valid data shifts a bubble (valid=0).
  - When adv=0, every stage holds.
  - in_ready = adv, combinational from out_valid/out_ready only; no dependence on in_valid.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Latency from input transfer to out_valid is exactly STAGES cycles when never stalled.
  - While out_valid=1 and out_ready=0: out_p, out_mode and out_tag are held stable.
  - Full throughput: one transaction per cycle with out_ready held high.
  - Ordering is strictly preserved; no drop, no duplication.
- Bubbles are not collapsed under stall; the pipeline holds as a unit.
- Statistics:
  - On each input transfer, the counter for in_mode increments, saturating at 2^CNT_W-1.
  - stat_clr=1 zeroes both counters in the next cycle and has priority over an increment in the same cycle.
- Reset mid-operation discards all in-flight transactions; no output is produced for them.

Optional Feature:
- Macro: APPROX_MUL_STATS_EN.
- Defined: statistics counters implemented as described.
- Undefined:
  - Counter logic is not built.
  - stat_exact_cnt and stat_approx_cnt are tied to 0.
  - stat_clr is ignored.
  - The port list is unchanged.

Decomposition:
- Package approx_mul_pkg:
  - mode constants MODE_EXACT=1'b0, MODE_APPROX=1'b1;
  - default parameter constants;
  - reference function approx_ref(a, b, mode, drop) used by the bench scoreboard.
- Sub-module approx_mul_core: combinational signed partial-product array and reduction, with DROP masking selected by mode. The top holds the pipeline registers, handshake and counters.

Test Plan (W=8, DROP=2, STAGES=2):
- Exact: a=7, b=7 -> out_p=0x0031. Approximate: a=7, b=7 -> out_p=0x0010, both 2 cycles after transfer.
- Corner: a=-128, b=-128 -> 0x4000 in both modes. a=127, b=-128 -> exact 0xC080, approx 0xC200. a=-1, b=1 -> exact 0xFFFF, approx 0x0000.
- Stall: back-to-back inputs tags 0..7, out_ready low for cycles 4-8:
  - in_ready low while stalled;
  - out_p/out_tag stable during the stall;
  - tags emerge 0..7 in order with no loss or duplication.
- Throughput: 100 random transactions, out_ready=1 -> one result per cycle, all matching approx_ref.
- Reset mid-stream: rst=0 with 2 transactions in flight -> out_valid=0 immediately. After release, no stale outputs appear; first new input appears after 2 cycles.
- Stats (APPROX_MUL_STATS_EN):
  - 5 exact + 3 approx transfers -> counts 5/3;
  - stat_clr asserted with a simultaneous transfer -> both counts 0;
  - CNT_W=4 with 20 approx transfers -> count saturates at 15.
